// File: rtl/id_exe_reg.sv
// id_exe_reg: ID/EXE pipeline register with stall (freeze), bubble insertion
// (flush) and a saturating count of inserted bubbles.
// Optional feature: define ID_EXE_FWD_EN to add src1/src2 register numbers
// for the forwarding unit.
// Priority at every clock edge: flush > freeze > normal load.
module id_exe_reg (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        flush,
  input  logic        WB_EN_in,
  input  logic        MEM_R_EN_in,
  input  logic        MEM_W_EN_in,
  input  logic        B_in,
  input  logic        S_in,
  input  logic [3:0]  EXE_CMD_in,
  input  logic [31:0] PC_in,
  input  logic [31:0] Val_Rn_in,
  input  logic [31:0] Val_Rm_in,
  input  logic        imm_in,
  input  logic [11:0] Shift_operand_in,
  input  logic [23:0] Signed_imm_24_in,
  input  logic [3:0]  Dest_in,
  input  logic [3:0]  SR_in,
`ifdef ID_EXE_FWD_EN
  input  logic [3:0]  src1_in,
  input  logic [3:0]  src2_in,
  output logic [3:0]  src1_out,
  output logic [3:0]  src2_out,
`endif
  output logic        WB_EN_out,
  output logic        MEM_R_EN_out,
  output logic        MEM_W_EN_out,
  output logic        B_out,
  output logic        S_out,
  output logic [3:0]  EXE_CMD_out,
  output logic [31:0] PC_out,
  output logic [31:0] Val_Rn_out,
  output logic [31:0] Val_Rm_out,
  output logic        imm_out,
  output logic [11:0] Shift_operand_out,
  output logic [23:0] Signed_imm_24_out,
  output logic [3:0]  Dest_out,
  output logic [3:0]  SR_out,
  output logic        valid_out,
  output logic [15:0] bubble_cnt
);

  typedef enum logic {
    ST_BUBBLE = 1'b0,
    ST_VALID  = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic        r_wb_en;
  logic        r_mem_r_en;
  logic        r_mem_w_en;
  logic        r_b;
  logic        r_s;
  logic [3:0]  r_exe_cmd;
  logic [31:0] r_pc;
  logic [31:0] r_val_rn;
  logic [31:0] r_val_rm;
  logic        r_imm;
  logic [11:0] r_shift_operand;
  logic [23:0] r_signed_imm_24;
  logic [3:0]  r_dest;
  logic [3:0]  r_sr;
  logic [15:0] r_bubble_cnt;
`ifdef ID_EXE_FWD_EN
  logic [3:0]  r_src1;
  logic [3:0]  r_src2;
`endif

  // A load happens only when neither flush nor freeze is asserted.
  logic w_load;
  assign w_load = !flush && !freeze;

  // Counter never wraps: once all ones it stays there.
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    if (v == 16'hFFFF) sat_inc = v;
    else               sat_inc = v + 16'd1;
  endfunction

  // State register: reset leaves the EXE stage holding a bubble.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_BUBBLE;
    else      r_state <= w_state_nxt;
  end

  // Next state: flush -> BUBBLE, load -> VALID, freeze -> unchanged.
  always_comb begin
    w_state_nxt = r_state;
    if (flush)       w_state_nxt = ST_BUBBLE;
    else if (w_load) w_state_nxt = ST_VALID;
  end

  // Pipeline fields: cleared by reset and by flush, held on freeze.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst || flush) begin
      r_wb_en         <= 1'b0;
      r_mem_r_en      <= 1'b0;
      r_mem_w_en      <= 1'b0;
      r_b             <= 1'b0;
      r_s             <= 1'b0;
      r_exe_cmd       <= 4'd0;
      r_pc            <= 32'd0;
      r_val_rn        <= 32'd0;
      r_val_rm        <= 32'd0;
      r_imm           <= 1'b0;
      r_shift_operand <= 12'd0;
      r_signed_imm_24 <= 24'd0;
      r_dest          <= 4'd0;
      r_sr            <= 4'd0;
`ifdef ID_EXE_FWD_EN
      r_src1          <= 4'd0;
      r_src2          <= 4'd0;
`endif
    end else if (!freeze) begin
      r_wb_en         <= WB_EN_in;
      r_mem_r_en      <= MEM_R_EN_in;
      r_mem_w_en      <= MEM_W_EN_in;
      r_b             <= B_in;
      r_s             <= S_in;
      r_exe_cmd       <= EXE_CMD_in;
      r_pc            <= PC_in;
      r_val_rn        <= Val_Rn_in;
      r_val_rm        <= Val_Rm_in;
      r_imm           <= imm_in;
      r_shift_operand <= Shift_operand_in;
      r_signed_imm_24 <= Signed_imm_24_in;
      r_dest          <= Dest_in;
      r_sr            <= SR_in;
`ifdef ID_EXE_FWD_EN
      r_src1          <= src1_in;
      r_src2          <= src2_in;
`endif
    end
  end

  // Bubble counter: one per flush edge, saturating; reset is not a bubble.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       r_bubble_cnt <= 16'd0;
    else if (flush) r_bubble_cnt <= sat_inc(r_bubble_cnt);
  end

  assign WB_EN_out         = r_wb_en;
  assign MEM_R_EN_out      = r_mem_r_en;
  assign MEM_W_EN_out      = r_mem_w_en;
  assign B_out             = r_b;
  assign S_out             = r_s;
  assign EXE_CMD_out       = r_exe_cmd;
  assign PC_out            = r_pc;
  assign Val_Rn_out        = r_val_rn;
  assign Val_Rm_out        = r_val_rm;
  assign imm_out           = r_imm;
  assign Shift_operand_out = r_shift_operand;
  assign Signed_imm_24_out = r_signed_imm_24;
  assign Dest_out          = r_dest;
  assign SR_out            = r_sr;
  assign valid_out         = (r_state == ST_VALID);
  assign bubble_cnt        = r_bubble_cnt;
`ifdef ID_EXE_FWD_EN
  assign src1_out          = r_src1;
  assign src2_out          = r_src2;
`endif

endmodule
